// File: rtl/req_arb_pkg.sv
// Shared sizing for the request arbiter: default port count/width, per-port
// FIFO depth and the port-index width helper.
package req_arb_pkg;
  localparam int DEF_N      = 4;
  localparam int DEF_WIDTH  = 32;
  localparam int PORT_DEPTH = 2;

  function automatic int port_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/req_port_fifo.sv
// Two-entry per-port request FIFO; head is always entry 0, pop shifts down.
// Caller guarantees no push when full and no pop when empty.
module req_port_fifo
  import req_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);
  logic [WIDTH-1:0] mem0, mem1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      mem0  <= '0;
      mem1  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) mem0 <= din;
          else               mem1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          mem0  <= mem1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // count unchanged; new word lands behind whatever survives the pop
          if (count == 2'(PORT_DEPTH)) begin
            mem0 <= mem1;
            mem1 <= din;
          end else begin
            mem0 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = mem0;
endmodule

// File: rtl/req_arbiter.sv
// N-port round-robin request arbiter feeding a single NoC request FIFO.
// Each port buffers up to two words; one word is issued per cycle at most.
module req_arbiter
  import req_arb_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N-1:0]       req_write,
  input  logic [N*WIDTH-1:0] req_data,
  output logic [N-1:0]       req_full,
  output logic [N-1:0]       req_almost_full,
  input  logic               noc_full,
  input  logic               noc_almost_full,
  output logic [WIDTH-1:0]   dataOut,
  output logic               write,
  output logic [N-1:0]       ovf_err
);
  localparam int IW = port_idx_w(N);

  logic [N-1:0][WIDTH-1:0] head;
  logic [N-1:0][1:0]       cnt;
  logic [N-1:0]            push, pop, ovf_set;
  logic [IW-1:0]           last_grant, sel;
  logic                    found, issue_ok;

  // A pending write already consumes one NoC slot, so almost-full gates it.
  assign issue_ok = (write & ~noc_almost_full) | (~write & ~noc_full);

  always_comb begin
    int j;
    j     = 0;
    sel   = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(last_grant) + k) % N;
      if (!found && cnt[j] != 2'd0) begin
        found = 1'b1;
        sel   = IW'(j);
      end
    end
  end

  always_comb begin
    pop = '0;
    if (issue_ok && found) pop[sel] = 1'b1;
  end

  for (genvar g = 0; g < N; g++) begin : g_port
    logic wr_ok, is_full;
    assign wr_ok           = req_write[g] & req_data[g*WIDTH];
    assign is_full         = (cnt[g] == 2'(PORT_DEPTH));
    assign push[g]         = wr_ok & (~is_full | pop[g]);
    assign ovf_set[g]      = wr_ok & is_full & ~pop[g];
    assign req_full[g]     = is_full;
    assign req_almost_full[g] = (cnt[g] != 2'd0);

    req_port_fifo #(.WIDTH(WIDTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push[g]),
      .pop     (pop[g]),
      .din     (req_data[g*WIDTH +: WIDTH]),
      .count   (cnt[g]),
      .head    (head[g])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      write      <= 1'b0;
      dataOut    <= '0;
      ovf_err    <= '0;
      last_grant <= IW'(N-1);
    end else begin
      ovf_err <= ovf_err | ovf_set;
      if (issue_ok && found) begin
        write      <= 1'b1;
        dataOut    <= head[sel];
        last_grant <= sel;
      end else begin
        write   <= 1'b0;
        dataOut <= '0;
      end
    end
  end
endmodule

// File: doc/req_arbiter.md
REQ_ARBITER -- requirements
Module: req_arbiter

Interface
REQ-001 Parameter N, default 4: number of requester ports, range 2..8.
REQ-002 Parameter WIDTH, default 32: request word width {ID,E,W,L}; bit 0 is the valid flag.
REQ-003 Port clk  input  1: the single clock; all state changes on its rising edge.
REQ-004 Port reset_n  input  1: asynchronous, active-low reset.
REQ-005 Port req_write  input  N: per-port write strobe from each requester.
REQ-006 Port req_data  input  N*WIDTH: per-port request word; port i occupies bits [i*WIDTH +: WIDTH].
REQ-007 Port req_full  output  N: per-port full indication returned to requester i.
REQ-008 Port req_almost_full  output  N: per-port almost-full indication returned to requester i.
REQ-009 Port noc_full  input  1: full indication from the NoC request FIFO.
REQ-010 Port noc_almost_full  input  1: almost-full indication from the NoC request FIFO.
REQ-011 Port dataOut  output  WIDTH: registered request word to the NoC request FIFO.
REQ-012 Port write  output  1: registered write strobe to the NoC request FIFO.
REQ-013 Port ovf_err  output  N: sticky per-port overflow flag.

Function
REQ-014 Each port shall own a 2-entry FIFO with count 0..2.
REQ-015 req_full[i] shall be (count_i==2); req_almost_full[i] shall be (count_i>=1); both are combinational from registered count.
REQ-016 A port FIFO shall push req_data[i] when req_write[i]=1 and req_data[i][0]=1 and the FIFO is not full (a same-cycle pop on that port counts as not full).
REQ-017 A write to a full port with no same-cycle pop shall drop the word and set ovf_err[i]; ovf_err clears only on reset.
REQ-018 A write with bit 0 = 0 shall be ignored silently: no push, no error.
REQ-019 NoC issue shall be allowed when (write & ~noc_almost_full) | (~write & ~noc_full), evaluated on the current registered write.
REQ-020 When issue is allowed and at least one port is non-empty, the arbiter shall select one port round-robin, starting the search at last_grant+1 mod N.
REQ-021 At that edge the arbiter shall pop the selected head, set write<=1 and dataOut<=head word, and set last_grant<=selected port.
REQ-022 Otherwise write<=0 and dataOut<=0; dataOut shall be 0 whenever write=0.
REQ-023 Latency: a word pushed at edge k shall reach dataOut no earlier than edge k+1.
REQ-024 Simultaneous push and pop on one port: count unchanged and FIFO order preserved.
REQ-025 The arbiter shall issue at most one word per cycle; no word shall be duplicated or reordered within a port.
REQ-026 Fairness: a non-empty port shall be granted within N issue-allowed cycles.

Reset
REQ-027 Assertion of reset_n=0 shall immediately clear all FIFO counts, write, dataOut, ovf_err, and set last_grant to N-1.
REQ-028 Reset mid-operation shall discard all buffered words; no partial word shall be issued after release.
REQ-029 The first grant after reset shall go to the lowest-indexed non-empty port.

Structure
REQ-030 Package req_arb_pkg shall hold the default N and WIDTH, the constant PORT_DEPTH=2, and the port-index width function.
REQ-031 Sub-module req_port_fifo (2-entry, push/pop/count/head) shall be instantiated N times; the round-robin logic stays in req_arbiter.

Verification
REQ-032 Single word: port 0 writes 0x00000011 with noc_full=0 -> write=1, dataOut=0x00000011 one edge later; req_almost_full[0] high for exactly one cycle.
REQ-033 All four ports write 0x...01/03/05/07 in the same cycle -> issues occur in order port 0,1,2,3 on consecutive cycles.
REQ-034 Back-pressure: noc_full=1 with ports loaded -> write stays 0; on release, noc_almost_full=1 while write=1 -> write drops after a single word.
REQ-035 Overflow: port 2 writes 3 words on back-to-back cycles while noc_full=1 -> third word dropped, ovf_err=4'b0100, 2 words later issued in order.
REQ-036 Invalid word: req_data bit 0 = 0 with req_write=1 -> no push, no error.
REQ-037 Reset mid-stream: reset_n pulled low with 5 words buffered -> outputs 0 immediately; after release write stays 0 until a new push.
